// File: rtl/lsu_rmw_if.sv
// lsu_rmw_if: bundles the CPU-side request/response signals and the
// word-only data-memory port of the load/store unit.
//
// Handshake: the CPU raises req with the request fields valid. The unit
// samples req only while idle (busy=0), and the request is taken on the
// first such rising edge. From then on busy stays high and req is ignored
// until the single-cycle done pulse, which carries err and rdata. No
// request is queued.
//
// Signals (slave = the load/store unit):
//   req, we, size, sext, addr, wdata, pc   CPU -> unit request
//   busy, done, err, rdata                  unit -> CPU status/response
//   mem_we, mem_addr, mem_wdata             unit -> data memory
//   mem_rdata                               data memory -> unit (combinational)
interface lsu_rmw_if #(
  parameter int MEM_AW = 10
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       pc;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req, we, size, sext, addr, wdata, pc, mem_rdata,
    output busy, done, err, rdata, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, size, sext, addr, wdata, pc, mem_rdata,
    input  busy, done, err, rdata, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store initiator between the CPU datapath and a word-only
// data memory. Byte/half stores are done as read-modify-write; byte/half
// loads are lane-selected and sign- or zero-extended. Misaligned or
// reserved-size requests finish with err and never touch memory.
//
// Ports:
//   clk      clock
//   reset    synchronous, active-high reset
//   bus      lsu_rmw_if.slave: CPU request/response + data-memory port
//   state_o  current FSM state (debug): 0 IDLE, 1 READ, 2 WRITE, 3 RESP
//
// Optional build macro LSU_TRACE_EN: prints one line per committed store
// ("@pc: *word_addr <= data"). Without it there is no trace logic and the
// behaviour and timing are identical.
module lsu_rmw #(
  parameter int MEM_AW = 10
) (
  input  logic       clk,
  input  logic       reset,
  lsu_rmw_if.slave   bus,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  // Only the bits that reach the memory (and select lanes) are kept;
  // higher address bits alias.
  logic [MEM_AW+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         word_q, word_d;
  logic                err_q, err_d;

  logic                bad_req;
  logic [31:0]         merged;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [31:0]         load_val;

  // Reserved size, or a half/word not naturally aligned.
  always_comb begin
    bad_req = 1'b0;
    case (bus.size)
      2'b01:   bad_req = bus.addr[0];
      2'b10:   bad_req = (bus.addr[1:0] != 2'b00);
      2'b11:   bad_req = 1'b1;
      default: bad_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          size_d  = bus.size;
          sext_d  = bus.sext;
          addr_d  = bus.addr[MEM_AW+1:0];
          wdata_d = bus.wdata;
          err_d   = bad_req;
          if (bad_req) begin
            state_d = S_RESP;
          end else if (bus.we && (bus.size == 2'b10)) begin
            // Full-word store needs no old data.
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        word_d  = bus.mem_rdata;
        state_d = we_q ? S_WRITE : S_RESP;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Store merge: replace the addressed lane(s) of the word read back.
  always_comb begin
    merged = word_q;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // Load extraction: little-endian lane select, then extend.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = word_q[7:0];
      2'd1:    byte_sel = word_q[15:8];
      2'd2:    byte_sel = word_q[23:16];
      default: byte_sel = word_q[31:24];
    endcase
    half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];
    case (size_q)
      2'b00:   load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_val = word_q;
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_RESP);
  assign bus.err       = (state_q == S_RESP) && err_q;
  assign bus.rdata     = ((state_q == S_RESP) && !we_q && !err_q) ? load_val : 32'd0;
  // Gated by reset so a reset landing in WRITE never commits the store.
  assign bus.mem_we    = (state_q == S_WRITE) && !reset;
  assign bus.mem_addr  = addr_q[MEM_AW+1:2];
  assign bus.mem_wdata = merged;
  assign state_o       = state_q;

`ifdef LSU_TRACE_EN
  logic [31:0] pc_q;
  logic [31:0] trace_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= '0;
      trace_addr_q <= '0;
    end else if ((state_q == S_IDLE) && bus.req) begin
      pc_q         <= bus.pc;
      trace_addr_q <= bus.addr;
    end
  end

  always @(posedge clk) begin
    if (bus.mem_we) begin
      $display("@%h: *%h <= %h", pc_q, {trace_addr_q[31:2], 2'b00}, bus.mem_wdata);
    end
  end
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
module tb_lsu_rmw;

  localparam int MEM_AW = 10;
  // Response entry: {issue_cycle[15:0], latency[3:0], err, rdata[31:0]}
  localparam int RW = 53;
  // Write entry: {issue_cycle[15:0], latency[3:0], word_addr[9:0], wdata[31:0]}
  localparam int WW = 62;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] state_o;
  int cyc = 0;

  lsu_rmw_if #(.MEM_AW(MEM_AW)) bus ();

  lsu_rmw #(.MEM_AW(MEM_AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:(1<<MEM_AW)-1];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_a = '0;
  logic [31:0] pl_d = '0;
  int          wr_cnt = 0;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic [WW-1:0] wr_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every done pulse and every memory write against
  // the queued expectations.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    logic [WW-1:0] w;
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no response (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("resp_err", {31'd0, bus.err}, {31'd0, e[32]});
        check("resp_rdata", bus.rdata, e[31:0]);
        check("resp_latency", cyc - int'(e[52:37]), {28'd0, e[36:33]});
      end
    end
    if (bus.mem_we) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got mem_we=1 addr %h data %h expected no write (t=%0t)",
                 bus.mem_addr, bus.mem_wdata, $time);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", {22'd0, bus.mem_addr}, {22'd0, w[41:32]});
        check("wr_data", bus.mem_wdata, w[31:0]);
        check("wr_latency", cyc - int'(w[61:46]), {28'd0, w[45:42]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one request and waits until the unit is idle again.
  // hold=1 keeps req high for the whole transaction.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rd, input int e_lat,
                        input logic e_wr, input logic [31:0] e_wd, input int e_wlat,
                        input logic hold);
    int c0;
    int n;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.size  = sz;
    bus.sext  = sx;
    bus.addr  = a;
    bus.wdata = wd;
    bus.pc    = 32'h1000 + a;
    c0 = cyc;
    exp_q.push_back({c0[15:0], 4'(e_lat), e_err, e_rd});
    if (e_wr) wr_q.push_back({c0[15:0], 4'(e_wlat), a[11:2], e_wd});
    @(negedge clk);
    if (!hold) bus.req = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.req = 1'b0;
    if (n >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: got busy=1 after 20 cycles expected idle");
    end
  endtask

  task automatic load(input logic [1:0] sz, input logic sx, input logic [31:0] a,
                      input logic [31:0] e_rd);
    do_req(1'b0, sz, sx, a, 32'h0, 1'b0, e_rd, 2, 1'b0, 32'h0, 0, 1'b0);
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] e_wd);
    if (sz == 2'b10) do_req(1'b1, sz, 1'b0, a, wd, 1'b0, 32'h0, 2, 1'b1, e_wd, 1, 1'b0);
    else             do_req(1'b1, sz, 1'b0, a, wd, 1'b0, 32'h0, 3, 1'b1, e_wd, 2, 1'b0);
  endtask

  task automatic bad(input logic w, input logic [1:0] sz, input logic [31:0] a);
    do_req(w, sz, 1'b0, a, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, 1'b0, 32'h0, 0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wc;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sext = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.pc = '0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",   {31'd0, bus.busy},   32'd0);
    check("rst_done",   {31'd0, bus.done},   32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_rdata",  bus.rdata,           32'd0);
    check("rst_state",  {30'd0, state_o},    32'd0);
    check("rst_mem_addr", {22'd0, bus.mem_addr}, 32'd0);

    preload(10'd1, 32'h8899_AABB);
    preload(10'd2, 32'h1122_3344);
    preload(10'd4, 32'h5566_7788);

    // Sub-word and word loads
    load(2'b00, 1'b1, 32'h5, 32'hFFFF_FFAA);
    load(2'b00, 1'b0, 32'h5, 32'h0000_00AA);
    load(2'b01, 1'b1, 32'h6, 32'hFFFF_8899);
    load(2'b01, 1'b0, 32'h4, 32'h0000_AABB);
    load(2'b00, 1'b1, 32'h4, 32'hFFFF_FFBB);
    load(2'b00, 1'b0, 32'h7, 32'h0000_0088);
    load(2'b10, 1'b0, 32'h4, 32'h8899_AABB);

    // Read-modify-write stores
    store(2'b01, 32'hA, 32'h0000_BEEF, 32'hBEEF_3344);
    load(2'b10, 1'b0, 32'h8, 32'hBEEF_3344);
    store(2'b00, 32'h9, 32'h1234_5677, 32'hBEEF_7744);
    store(2'b01, 32'h8, 32'h0000_CAFE, 32'hBEEF_CAFE);
    load(2'b10, 1'b0, 32'h8, 32'hBEEF_CAFE);

    // Word store with req held high throughout: exactly one write
    wc = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1'b1, 32'hDEAD_BEEF, 1, 1'b1);
    repeat (2) @(negedge clk);
    check("held_req_write_count", wr_cnt - wc, 32'd1);
    check("held_req_idle", {30'd0, state_o}, 32'd0);
    load(2'b10, 1'b0, 32'h1000_000C, 32'hDEAD_BEEF);

    // Error cases: no memory access, done+err in cycle 1
    wc = wr_cnt;
    bad(1'b0, 2'b10, 32'h6);
    bad(1'b1, 2'b01, 32'h3);
    bad(1'b0, 2'b11, 32'h0);
    bad(1'b1, 2'b10, 32'h2);
    bad(1'b1, 2'b11, 32'h8);
    check("err_no_writes", wr_cnt - wc, 32'd0);
    check("err_mem_intact", mem[2], 32'hBEEF_CAFE);

    // Reset arriving while the byte store is in WRITE
    wc = wr_cnt;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sext = 1'b0;
    bus.addr = 32'h11; bus.wdata = 32'h0000_00AB;
    @(negedge clk);
    bus.req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rstw_state_write", {30'd0, state_o}, 32'd2);
    check("rstw_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rstw_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    check("rstw_state_idle", {30'd0, state_o}, 32'd0);
    check("rstw_busy", {31'd0, bus.busy}, 32'd0);
    check("rstw_done_after", {31'd0, bus.done}, 32'd0);
    check("rstw_no_write", wr_cnt - wc, 32'd0);
    check("rstw_mem_unchanged", mem[4], 32'h5566_7788);
    reset = 1'b0;
    @(negedge clk);
    load(2'b10, 1'b0, 32'h10, 32'h5566_7788);

    repeat (3) @(negedge clk);
    check("resp_queue_drained", exp_q.size(), 32'd0);
    check("write_queue_drained", wr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
